sync_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides. It owns the write and read pointers that drive the team's two-port, zero-latency-read RAM (`ram2p_0clk`), which it instantiates as its storage. It adds occupancy tracking, almost-full and almost-empty thresholds, and a sticky overflow flag. It is the standard buffering element between producer and consumer blocks in one clock domain.

---
 rtl/sync_fifo_pkg.sv | 28 ++
 rtl/ram2p_0clk.sv | 32 +++
 rtl/sync_fifo.sv | 105 ++++++++++
 tb/tb_sync_fifo.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared helpers for sync_fifo.
// Pointer types depend on AW, so they stay local to the FIFO. The helpers take
// pointers zero-extended to PtrW bits plus the address width.
package sync_fifo_pkg;

  localparam int unsigned PtrW = 32;

  // Full: wrap bits differ, address bits match.
  function automatic logic ptr_full(input logic [PtrW-1:0] wr_ptr,
                                    input logic [PtrW-1:0] rd_ptr,
                                    input int unsigned     aw);
    logic [PtrW-1:0] diff;
    logic [PtrW-1:0] mask;
    diff = wr_ptr ^ rd_ptr;
    mask = (PtrW'(1) << aw) - PtrW'(1);
    return diff[aw] && ((diff & mask) == '0);
  endfunction

  // Empty: wrap bit and address bits all match.
  function automatic logic ptr_empty(input logic [PtrW-1:0] wr_ptr,
                                     input logic [PtrW-1:0] rd_ptr,
                                     input int unsigned     aw);
    logic [PtrW-1:0] mask;
    mask = (PtrW'(1) << (aw + 1)) - PtrW'(1);
    return ((wr_ptr ^ rd_ptr) & mask) == '0;
  endfunction

endpackage

// File: rtl/ram2p_0clk.sv
// Two-port RAM: one synchronous write port and one combinational read port.
// Ports:
//   clk     - write clock
//   wen     - write enable
//   wr_addr - write address
//   wr_data - write data
//   rd_addr - read address
//   rd_data - read data, combinational from rd_addr
// Contents are not reset.
module ram2p_0clk #(
  parameter int unsigned DW = 18,
  parameter int unsigned AW = 7
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides.
// Ports:
//   clk, rst                     - clock and synchronous active-high reset
//   wr_valid, wr_ready, wr_data  - producer handshake and data
//   rd_valid, rd_ready, rd_data  - consumer handshake and head-of-FIFO data
//   count                        - occupancy 0..2**AW
//   almost_full, almost_empty    - threshold flags from registered count
//   ovf_err                      - sticky, set by a write offered while not ready
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DW        = 18,
  parameter int unsigned AW        = 7,
  parameter int unsigned AFULL_TH  = 2**AW - 4,
  parameter int unsigned AEMPTY_TH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          ovf_err
);

  localparam logic [AW:0] AfullTh  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AemptyTh = (AW+1)'(AEMPTY_TH);
  localparam logic [AW:0] One      = (AW+1)'(1);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        ovf_q, ovf_d;
  logic        full, empty, push, pop;

  assign full  = ptr_full(PtrW'(wr_ptr_q), PtrW'(rd_ptr_q), AW);
  assign empty = ptr_empty(PtrW'(wr_ptr_q), PtrW'(rd_ptr_q), AW);

  // Handshake outputs depend only on state and rst, never on wr_valid/rd_ready.
  assign wr_ready = !full && !rst;
  assign rd_valid = !empty && !rst;

  assign push = wr_valid && wr_ready;
  assign pop  = rd_valid && rd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + One;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + One;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + One;
      2'b01:   count_d = count_q - One;
      default: count_d = count_q;
    endcase
    if (wr_valid && !wr_ready && !rst) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign count   = count_q;
  assign ovf_err = ovf_q;

  // Flags are forced to their reset values while rst is held.
  assign almost_full  = !rst && (count_q >= AfullTh);
  assign almost_empty = rst || (count_q <= AemptyTh);

  ram2p_0clk #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk     (clk),
    .wen     (push),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  localparam int DW    = 18;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          ovf_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a plain queue plus a sticky flag.
  logic [DW-1:0] mq[$];
  logic          m_ovf = 1'b0;

  always #5 clk = ~clk;

  sync_fifo #(
    .DW(DW),
    .AW(AW),
    .AFULL_TH(AF),
    .AEMPTY_TH(AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_data      (rd_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ovf_err      (ovf_err)
  );

  // Advance one clock edge, update the model with the inputs present at that edge,
  // then settle 1 time unit past the edge.
  task automatic tick();
    int sz;
    @(posedge clk);
    sz = mq.size();
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (wr_valid && sz == DEPTH) m_ovf = 1'b1;
      if (rd_ready && sz > 0) void'(mq.pop_front());
      if (wr_valid && sz < DEPTH) mq.push_back(wr_data);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
    tick(); tick();
    n_vec++;
    if (wr_ready !== 1'b0 || rd_valid !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: wr_ready=%b rd_valid=%b ae=%b af=%b, want 0 0 1 0",
               wr_ready, rd_valid, almost_empty, almost_full);
    end
    rst = 1'b0;
    tick();
    n_vec++;
    if (wr_ready !== 1'b1 || rd_valid !== 1'b0 || count !== 4'd0 ||
        almost_empty !== 1'b1 || ovf_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: wr_ready=%b rd_valid=%b count=%0d ae=%b ovf=%b, want 1 0 0 1 0",
               wr_ready, rd_valid, count, almost_empty, ovf_err);
    end
  endtask

  task automatic test_fill();
    rd_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = DW'(i);
      tick();
      n_vec++;
      if (count !== 4'(i) || almost_full !== (i >= AF) || wr_ready !== (i < DEPTH) ||
          rd_valid !== 1'b1 || rd_data !== 18'h00001) begin
        n_err++;
        $display("FAIL fill[%0d]: count=%0d af=%b wr_ready=%b rd_valid=%b rd_data=%h, want %0d %b %b 1 00001",
                 i, count, almost_full, wr_ready, rd_valid, rd_data,
                 i, (i >= AF), (i < DEPTH));
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_overflow_drain();
    wr_valid = 1'b1; wr_data = 18'h3ffff; rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (ovf_err !== 1'b1 || count !== 4'd8) begin
        n_err++;
        $display("FAIL ovf[%0d]: ovf=%b count=%0d, want 1 8", i, ovf_err, count);
      end
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      n_vec++;
      if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin
        n_err++;
        $display("FAIL drain[%0d]: rd_valid=%b rd_data=%h, want 1 %h", i, rd_valid, rd_data, DW'(i));
      end
      tick();
    end
    rd_ready = 1'b0;
    n_vec++;
    if (rd_valid !== 1'b0 || count !== 4'd0 || ovf_err !== 1'b1) begin
      n_err++;
      $display("FAIL drain_end: rd_valid=%b count=%0d ovf=%b, want 0 0 1", rd_valid, count, ovf_err);
    end
  endtask

  task automatic test_stream();
    int nout = 0;
    for (int c = 0; c <= 40; c++) begin
      wr_valid = (c < 40); wr_data = DW'(18'h100 + c); rd_ready = 1'b1;
      #1;
      if (rd_valid) begin
        n_vec++;
        if (rd_data !== DW'(18'h100 + nout)) begin
          n_err++;
          $display("FAIL stream_data[%0d]: rd_data=%h, want %h", nout, rd_data, DW'(18'h100 + nout));
        end
        nout++;
      end
      tick();
      n_vec++;
      if (count !== ((c < 40) ? 4'd1 : 4'd0)) begin
        n_err++;
        $display("FAIL stream_count[%0d]: count=%0d, want %0d", c, count, (c < 40) ? 1 : 0);
      end
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    n_vec++;
    if (nout != 40) begin
      n_err++;
      $display("FAIL stream_total: got %0d words, want 40", nout);
    end
  endtask

  task automatic test_empty_push_pop();
    wr_valid = 1'b1; wr_data = 18'h2aaaa; rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0; rd_ready = 1'b0;
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 18'h2aaaa || count !== 4'd1) begin
      n_err++;
      $display("FAIL empty_pushpop: rd_valid=%b rd_data=%h count=%0d, want 1 2aaaa 1",
               rd_valid, rd_data, count);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = DW'(18'h500 + i);
      tick();
    end
    wr_valid = 1'b0;
    n_vec++;
    if (count !== 4'd5) begin
      n_err++;
      $display("FAIL mid_prefill: count=%0d, want 5", count);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (count !== 4'd0 || rd_valid !== 1'b0 || ovf_err !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: count=%0d rd_valid=%b ovf=%b, want 0 0 0", count, rd_valid, ovf_err);
    end
    wr_valid = 1'b1; wr_data = 18'h12345;
    tick();
    wr_valid = 1'b0;
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 18'h12345 || count !== 4'd1) begin
      n_err++;
      $display("FAIL mid_repush: rd_valid=%b rd_data=%h count=%0d, want 1 12345 1",
               rd_valid, rd_data, count);
    end
  endtask

  task automatic test_random();
    int sz;
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 99) == 0);
      wr_valid = ($urandom_range(0, 99) < 55);
      rd_ready = ($urandom_range(0, 99) < 45);
      wr_data  = DW'($urandom);
      tick();
      rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
      #1;
      sz = mq.size();
      n_vec++;
      if (count !== 4'(sz) || wr_ready !== (sz < DEPTH) || rd_valid !== (sz > 0) ||
          almost_full !== (sz >= AF) || almost_empty !== (sz <= AE) ||
          ovf_err !== m_ovf || (sz > 0 && rd_data !== mq[0])) begin
        n_err++;
        $display("FAIL random[%0d]: count=%0d wr_ready=%b rd_valid=%b af=%b ae=%b ovf=%b rd_data=%h, want count=%0d ovf=%b head=%h",
                 c, count, wr_ready, rd_valid, almost_full, almost_empty, ovf_err, rd_data,
                 sz, m_ovf, (sz > 0) ? mq[0] : '0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow_drain();
    test_stream();
    test_empty_push_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
